shift_acc_stage: RTL and testbench

- Downstream consumer of BARREL_SHIFTER inside each systolic-array PE.
- Accepts a stream of {mantissa, shift select, sign, last} beats over a valid/ready handshake and registers each beat.
- Drives the registered beat through BARREL_SHIFTER and accumulates the signed shifted terms into a saturating accumulator.
- On the last beat of a vector it emits one result, with element count and error flags, over a valid/ready handshake.

---
 rtl/pe_pkg.sv | 51 +++++
 rtl/barrel_shifter.sv | 21 ++
 rtl/shift_acc_stage.sv | 132 +++++++++++++
 tb/tb_shift_acc_stage.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/pe_pkg.sv
// pe_pkg: definitions shared by the processing-element datapath.
//   MANT_W / SEL_W      : mantissa and shift-select widths of an input beat
//   SHIFT_MAX           : largest shift amount that is considered valid
//   SHIFT_OUT_W         : width of the barrel shifter output
//   beat_t              : one input beat {mant, sel, neg, last}
//   sat_add()           : signed add with clamping to a caller-chosen width
package pe_pkg;

    localparam int MANT_W      = 12;
    localparam int SEL_W       = 5;
    localparam int SHIFT_MAX   = 20;
    localparam int SHIFT_OUT_W = 32;

    typedef struct packed {
        logic [MANT_W-1:0] mant;
        logic [SEL_W-1:0]  sel;
        logic              neg;
        logic              last;
    } beat_t;

    typedef struct packed {
        logic        sat;
        logic [63:0] val;
    } sat_res_t;

    // Operands arrive sign-extended to 64 bits; w (2..64) is the real
    // signed width. The sum is formed at 65 bits so it can never wrap,
    // then clamped to the w-bit signed range. val is sign-extended.
    function automatic sat_res_t sat_add(input logic signed [63:0] a,
                                         input logic signed [63:0] b,
                                         input int unsigned        w);
        logic signed [64:0] sum;
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        sat_res_t           r;
        sum   = 65'(a) + 65'(b);
        hi    = (64'sd1 <<< (w - 1)) - 64'sd1;
        lo    = -(64'sd1 <<< (w - 1));
        r.sat = 1'b0;
        r.val = sum[63:0];
        if (sum > 65'(hi)) begin
            r.sat = 1'b1;
            r.val = hi;
        end else if (sum < 65'(lo)) begin
            r.sat = 1'b1;
            r.val = lo;
        end
        return r;
    endfunction

endpackage

// File: rtl/barrel_shifter.sv
// barrel_shifter: left-shifts an unsigned mantissa into a wider word.
//   din  : unsigned mantissa (MANT_W bits)
//   sel  : shift amount (SEL_W bits)
//   dout : din << sel, zero-filled (SHIFT_OUT_W bits)
module barrel_shifter
    import pe_pkg::*;
(
    input  logic [MANT_W-1:0]      din,
    input  logic [SEL_W-1:0]       sel,
    output logic [SHIFT_OUT_W-1:0] dout
);

    // One mux level per select bit.
    always_comb begin
        dout = SHIFT_OUT_W'(din);
        for (int i = 0; i < SEL_W; i++) begin
            if (sel[i]) dout = dout << (1 << i);
        end
    end

endmodule

// File: rtl/shift_acc_stage.sv
// shift_acc_stage: registers shifted-mantissa beats and accumulates the
// signed terms of a vector into a saturating accumulator; one result per
// vector is emitted on the last beat.
//   clk, rst                 : rising-edge clock, synchronous active-high reset
//   in_valid/in_ready        : input beat handshake
//   in_mant/in_sel/in_neg    : mantissa, shift amount, subtract flag
//   in_last                  : final beat of the vector
//   out_valid/out_ready      : result handshake
//   out_data                 : signed accumulated result (ACC_W)
//   out_count                : beats in the vector (saturating, CNT_W)
//   out_sat                  : clamping happened somewhere in the vector
//   out_sel_err              : some beat had a shift amount above SHIFT_MAX
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both 1. A producer holding valid keeps its payload stable until the
// transfer; out_* fields stay stable while out_valid=1 and out_ready=0.
module shift_acc_stage
    import pe_pkg::*;
#(
    parameter int ACC_W = 40,
    parameter int CNT_W = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [MANT_W-1:0]       in_mant,
    input  logic [SEL_W-1:0]        in_sel,
    input  logic                    in_neg,
    input  logic                    in_last,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic signed [ACC_W-1:0] out_data,
    output logic [CNT_W-1:0]        out_count,
    output logic                    out_sat,
    output logic                    out_sel_err
);

    beat_t                    s1;
    beat_t                    in_beat;
    logic                     s1_valid;
    logic signed [ACC_W-1:0]  acc;
    logic [CNT_W-1:0]         count;
    logic                     sat_sticky;
    logic                     sel_err_sticky;

    logic [SHIFT_OUT_W-1:0]   shifted;
    logic [ACC_W-1:0]         term_mag;
    logic signed [ACC_W-1:0]  term;
    logic                     sel_bad;
    sat_res_t                 sum_res;
    logic signed [ACC_W-1:0]  sum_clamped;
    logic [CNT_W-1:0]         count_inc;
    logic                     hold;
    logic                     consume;

    assign in_beat = '{mant: in_mant, sel: in_sel, neg: in_neg, last: in_last};

    barrel_shifter u_shifter (
        .din  (s1.mant),
        .sel  (s1.sel),
        .dout (shifted)
    );

    // A finished vector in s1 cannot retire while the previous result
    // is still waiting downstream; that stall is the only backpressure.
    assign hold     = s1_valid && s1.last && out_valid && !out_ready;
    assign in_ready = !hold;
    assign consume  = s1_valid && !hold;

    always_comb begin
        sel_bad  = s1.sel > SEL_W'(SHIFT_MAX);
        term_mag = {{(ACC_W - SHIFT_OUT_W){1'b0}}, shifted};
        term     = '0;
        if (!sel_bad) term = s1.neg ? -term_mag : term_mag;
        sum_res     = sat_add(64'(acc), 64'(term), ACC_W);
        sum_clamped = sum_res.val[ACC_W-1:0];
        count_inc   = (count == '1) ? count : count + 1'b1;
    end

    // Upper bits of the clamped sum are only sign extension.
    if (ACC_W < 64) begin : g_sum_hi
        logic unused_sum_hi;
        assign unused_sum_hi = ^sum_res.val[63:ACC_W];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1             <= '0;
            s1_valid       <= 1'b0;
            acc            <= '0;
            count          <= '0;
            sat_sticky     <= 1'b0;
            sel_err_sticky <= 1'b0;
            out_valid      <= 1'b0;
            out_data       <= '0;
            out_count      <= '0;
            out_sat        <= 1'b0;
            out_sel_err    <= 1'b0;
        end else begin
            if (in_valid && in_ready) begin
                s1       <= in_beat;
                s1_valid <= 1'b1;
            end else if (consume) begin
                s1_valid <= 1'b0;
            end

            if (out_valid && out_ready) out_valid <= 1'b0;

            if (consume) begin
                if (s1.last) begin
                    // Overrides the drop above when transfer and load coincide.
                    out_valid      <= 1'b1;
                    out_data       <= sum_clamped;
                    out_count      <= count_inc;
                    out_sat        <= sat_sticky | sum_res.sat;
                    out_sel_err    <= sel_err_sticky | sel_bad;
                    acc            <= '0;
                    count          <= '0;
                    sat_sticky     <= 1'b0;
                    sel_err_sticky <= 1'b0;
                end else begin
                    acc            <= sum_clamped;
                    count          <= count_inc;
                    sat_sticky     <= sat_sticky | sum_res.sat;
                    sel_err_sticky <= sel_err_sticky | sel_bad;
                end
            end
        end
    end

endmodule

// File: tb/tb_shift_acc_stage.sv
// tb_shift_acc_stage: directed bench for shift_acc_stage, with one instance
// at the default ACC_W=40 and one at ACC_W=34 for saturation vectors.
module tb_shift_acc_stage;

    logic        clk = 1'b0;
    logic        rst = 1'b1;

    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [11:0] in_mant = '0;
    logic [4:0]  in_sel = '0;
    logic        in_neg = 1'b0;
    logic        in_last = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [39:0] out_data;
    logic [15:0] out_count;
    logic        out_sat;
    logic        out_sel_err;

    logic        in_valid_b = 1'b0;
    logic        in_ready_b;
    logic [11:0] in_mant_b = '0;
    logic [4:0]  in_sel_b = '0;
    logic        in_neg_b = 1'b0;
    logic        in_last_b = 1'b0;
    logic        out_valid_b;
    logic        out_ready_b = 1'b1;
    logic [33:0] out_data_b;
    logic [15:0] out_count_b;
    logic        out_sat_b;
    logic        out_sel_err_b;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    shift_acc_stage #(.ACC_W(40), .CNT_W(16)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_mant(in_mant), .in_sel(in_sel), .in_neg(in_neg), .in_last(in_last),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_count(out_count),
        .out_sat(out_sat), .out_sel_err(out_sel_err)
    );

    shift_acc_stage #(.ACC_W(34), .CNT_W(16)) dut34 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid_b), .in_ready(in_ready_b),
        .in_mant(in_mant_b), .in_sel(in_sel_b), .in_neg(in_neg_b), .in_last(in_last_b),
        .out_valid(out_valid_b), .out_ready(out_ready_b),
        .out_data(out_data_b), .out_count(out_count_b),
        .out_sat(out_sat_b), .out_sel_err(out_sel_err_b)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [11:0] m, input logic [4:0] s,
                        input logic n, input logic l);
        in_valid = 1'b1;
        in_mant  = m;
        in_sel   = s;
        in_neg   = n;
        in_last  = l;
        step();
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic send_b(input logic [11:0] m, input logic [4:0] s,
                          input logic n, input logic l);
        in_valid_b = 1'b1;
        in_mant_b  = m;
        in_sel_b   = s;
        in_neg_b   = n;
        in_last_b  = l;
        step();
        in_valid_b = 1'b0;
        in_last_b  = 1'b0;
    endtask

    task automatic wait_out(input string tag);
        int n = 0;
        while (!out_valid && n < 20) begin
            step();
            n++;
        end
        chk(tag, 64'(out_valid), 64'd1);
    endtask

    task automatic wait_out_b(input string tag);
        int n = 0;
        while (!out_valid_b && n < 20) begin
            step();
            n++;
        end
        chk(tag, 64'(out_valid_b), 64'd1);
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        #1;
        chk("reset_out_valid", 64'(out_valid), 64'd0);
        chk("reset_out_data",  64'(out_data),  64'd0);
        chk("reset_out_count", 64'(out_count), 64'd0);
        chk("reset_in_ready",  64'(in_ready),  64'd1);

        // Single beat, exact two-cycle latency.
        send(12'hFFF, 5'd20, 1'b0, 1'b1);
        chk("lat_not_yet", 64'(out_valid), 64'd0);
        step();
        chk("lat_valid",   64'(out_valid),   64'd1);
        chk("t1_data",     64'(out_data),    64'h00_FFF0_0000);
        chk("t1_count",    64'(out_count),   64'd1);
        chk("t1_sat",      64'(out_sat),     64'd0);
        chk("t1_sel_err",  64'(out_sel_err), 64'd0);
        step();
        chk("t1_drain", 64'(out_valid), 64'd0);

        // 1 + 3*16 - 2*2 = 45
        send(12'h001, 5'd0, 1'b0, 1'b0);
        send(12'h003, 5'd4, 1'b0, 1'b0);
        send(12'h002, 5'd1, 1'b1, 1'b1);
        wait_out("t2_valid");
        chk("t2_data",  64'(out_data),  64'd45);
        chk("t2_count", 64'(out_count), 64'd3);
        step();

        send(12'h001, 5'd0, 1'b1, 1'b1);
        wait_out("t2n_valid");
        chk("t2n_data",  64'(out_data),  64'hFF_FFFF_FFFF);
        chk("t2n_count", 64'(out_count), 64'd1);
        step();

        // Out-of-range shift contributes nothing but flags the vector.
        send(12'h0FF, 5'd21, 1'b0, 1'b0);
        send(12'h010, 5'd2,  1'b0, 1'b1);
        wait_out("t3_valid");
        chk("t3_data",    64'(out_data),    64'h40);
        chk("t3_count",   64'(out_count),   64'd2);
        chk("t3_sel_err", 64'(out_sel_err), 64'd1);
        chk("t3_sat",     64'(out_sat),     64'd0);
        step();
        send(12'h005, 5'd0, 1'b0, 1'b1);
        wait_out("t3c_valid");
        chk("t3c_data",    64'(out_data),    64'd5);
        chk("t3c_sel_err", 64'(out_sel_err), 64'd0);
        step();
        chk("t3c_drain", 64'(out_valid), 64'd0);

        // Backpressure with two back-to-back single-beat vectors.
        out_ready = 1'b0;
        send(12'h001, 5'd0, 1'b0, 1'b1);
        send(12'h002, 5'd0, 1'b0, 1'b1);
        chk("bp_valid1",    64'(out_valid), 64'd1);
        chk("bp_data1",     64'(out_data),  64'd1);
        chk("bp_in_ready0", 64'(in_ready),  64'd0);
        step();
        step();
        chk("bp_hold_valid", 64'(out_valid), 64'd1);
        chk("bp_hold_data",  64'(out_data),  64'd1);
        chk("bp_hold_ready", 64'(in_ready),  64'd0);
        out_ready = 1'b1;
        #1;
        chk("bp_ready_comb", 64'(in_ready), 64'd1);
        step();
        out_ready = 1'b0;
        #1;
        chk("bp_valid2",  64'(out_valid), 64'd1);
        chk("bp_data2",   64'(out_data),  64'd2);
        chk("bp_count2",  64'(out_count), 64'd1);
        chk("bp_in_rdy1", 64'(in_ready),  64'd1);
        step();
        chk("bp_data2_stable", 64'(out_data), 64'd2);
        out_ready = 1'b1;
        step();
        chk("bp_drained", 64'(out_valid), 64'd0);

        // Saturation at ACC_W=34, positive then negative.
        for (int i = 0; i < 4; i++) send_b(12'hFFF, 5'd20, 1'b0, (i == 3));
        wait_out_b("s_pos_valid");
        chk("s_pos_data",  64'(out_data_b),  64'h1_FFFF_FFFF);
        chk("s_pos_sat",   64'(out_sat_b),   64'd1);
        chk("s_pos_count", 64'(out_count_b), 64'd4);
        step();
        for (int i = 0; i < 4; i++) send_b(12'hFFF, 5'd20, 1'b1, (i == 3));
        wait_out_b("s_neg_valid");
        chk("s_neg_data", 64'(out_data_b), 64'h2_0000_0000);
        chk("s_neg_sat",  64'(out_sat_b),  64'd1);
        step();

        // Reset in the middle of a vector discards the partial sum.
        send(12'h001, 5'd0, 1'b0, 1'b0);
        send(12'h002, 5'd0, 1'b0, 1'b0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        #1;
        chk("mr_out_valid", 64'(out_valid),   64'd0);
        chk("mr_out_data",  64'(out_data),    64'd0);
        chk("mr_out_count", 64'(out_count),   64'd0);
        chk("mr_out_sat",   64'(out_sat),     64'd0);
        chk("mr_sel_err",   64'(out_sel_err), 64'd0);
        chk("mr_in_ready",  64'(in_ready),    64'd1);
        send(12'h005, 5'd0, 1'b0, 1'b1);
        wait_out("mr_valid");
        chk("mr_data",  64'(out_data),  64'd5);
        chk("mr_count", 64'(out_count), 64'd1);
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
